wb_rx_ber_sink: RTL and testbench

- Wishbone-style responder that terminates the OFDM receiver's demodulated symbol stream (4-bit 16-QAM or 2-bit QPSK symbols).
- Acknowledges each write beat and compares received bits against a locally regenerated PRBS-9 reference.
- Reports per-frame error and correct-bit counts.
- Sits at the RX output, as the sink counterpart of the bit-symbol source that feeds the transmitter.

---
 rtl/ber_pkg.sv | 37 +++
 rtl/ber_prbs9.sv | 43 ++++
 rtl/wb_rx_ber_sink.sv | 206 ++++++++++++++++++++
 tb/tb_wb_rx_ber_sink.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ber_pkg.sv
// Shared types and constants for the PRBS-9 bit-error-rate sink.
// Used by ber_prbs9 and wb_rx_ber_sink.
package ber_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ber_state_e;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_QPSK = 2'd1,
    MODE_QAM  = 2'd2
  } ber_mode_e;

  localparam int BITS_QAM  = 4;
  localparam int BITS_QPSK = 2;

  localparam int PRBS_LEN   = 9;
  localparam int PRBS_TAP_A = 8;
  localparam int PRBS_TAP_B = 4;

  // Frame totals for the reference frame length; scaled in the top for other lengths.
  localparam int FRAME_SYMS_REF  = 96;
  localparam int FRAME_BITS_QAM  = 384;
  localparam int FRAME_BITS_QPSK = 192;

  function automatic logic [PRBS_LEN-1:0] prbs9_step(input logic [PRBS_LEN-1:0] s);
    return {s[PRBS_LEN-2:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
  endfunction

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/ber_prbs9.sv
// PRBS-9 (x^9+x^5+1) reference generator: seed load, advance by 2 or 4 bits,
// next four output bits presented MSB-first (exp_bits[3] is the oldest bit).
module ber_prbs9
  import ber_pkg::*;
#(
  parameter logic [8:0] SEED = 9'h1FF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       adv2,
  input  logic       adv4,
  output logic [3:0] exp_bits
);

  logic [PRBS_LEN-1:0] lfsr_q, lfsr_d;
  logic [4:0][PRBS_LEN-1:0] st;

  always_comb begin
    st[0] = lfsr_q;
    for (int k = 0; k < 4; k++) begin
      st[k+1] = prbs9_step(st[k]);
    end
    exp_bits = {st[0][PRBS_LEN-1], st[1][PRBS_LEN-1], st[2][PRBS_LEN-1], st[3][PRBS_LEN-1]};
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED;
    end else if (adv4) begin
      lfsr_d = st[4];
    end else if (adv2) begin
      lfsr_d = st[2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/wb_rx_ber_sink.sv
// Wishbone write sink that checks received 16-QAM/QPSK symbols against PRBS-9
// and reports per-frame error/correct counts. Optional ERR_ACCUM_EN adds err_accum.
module wb_rx_ber_sink
  import ber_pkg::*;
#(
  parameter int         FRAME_SYMS = 96,
  parameter logic [8:0] PRBS_SEED  = 9'h1FF,
  parameter int         CNT_W      = 10
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [3:0]       DAT_I,
  input  logic             CYC_I,
  input  logic             STB_I,
  input  logic             WE_I,
  output logic             ACK_O,
  input  logic             QAM,
  input  logic             QPSK,
  output logic [CNT_W-1:0] funcE,
  output logic [CNT_W-1:0] correctbits,
  output logic             frame_done,
  output logic             frame_abort,
  output logic             mode_err,
  output logic [15:0]      frame_cnt
`ifdef ERR_ACCUM_EN
  ,
  output logic [23:0]      err_accum
`endif
);

  localparam int BEAT_W = $clog2(FRAME_SYMS + 1);
  localparam logic [CNT_W-1:0] TOT_QAM  = CNT_W'(FRAME_BITS_QAM * FRAME_SYMS / FRAME_SYMS_REF);
  localparam logic [CNT_W-1:0] TOT_QPSK = CNT_W'(FRAME_BITS_QPSK * FRAME_SYMS / FRAME_SYMS_REF);

  ber_state_e       state_q, state_d;
  ber_mode_e        mode_q, mode_d;
  logic             need_low_q, need_low_d;
  logic             ack_q, ack_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] funce_q, funce_d;
  logic [CNT_W-1:0] correct_q, correct_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic             mode_err_q, mode_err_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic             any_beat, wr_beat;
  logic [3:0]       exp_bits;
  logic [3:0]       diff;
  logic [CNT_W-1:0] frame_err, frame_ok;

  // The ~ack_q term limits acceptance to one beat every two cycles.
  assign any_beat = (state_q == ST_RUN) && CYC_I && STB_I && !ack_q;
  assign wr_beat  = any_beat && WE_I;

  ber_prbs9 #(.SEED(PRBS_SEED)) u_prbs (
    .clk      (CLK_I),
    .rst_n    (RST_I),
    .load     (state_q == ST_IDLE),
    .adv2     (wr_beat && (mode_q == MODE_QPSK)),
    .adv4     (wr_beat && (mode_q == MODE_QAM)),
    .exp_bits (exp_bits)
  );

  always_comb begin
    diff = 4'd0;
    case (mode_q)
      MODE_QAM:  diff = DAT_I ^ exp_bits;
      MODE_QPSK: diff = {2'b00, DAT_I[1:0] ^ exp_bits[3:2]};
      default:   diff = 4'd0;
    endcase
  end

  always_comb begin
    frame_err = err_q;
    frame_ok  = '0;
    case (mode_q)
      MODE_QAM:  frame_ok = TOT_QAM - err_q;
      MODE_QPSK: frame_ok = TOT_QPSK - err_q;
      default: begin
        frame_err = '0;
        frame_ok  = '0;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    need_low_d  = need_low_q;
    ack_d       = any_beat;
    beat_d      = beat_q;
    err_d       = err_q;
    funce_d     = funce_q;
    correct_d   = correct_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    mode_err_d  = mode_err_q;
    frame_cnt_d = frame_cnt_q;
    if (!CYC_I) begin
      need_low_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (CYC_I && !need_low_q) begin
          state_d = ST_RUN;
          beat_d  = '0;
          err_d   = '0;
          if (QAM) begin
            mode_d = MODE_QAM;
          end else if (QPSK) begin
            mode_d = MODE_QPSK;
          end else begin
            mode_d     = MODE_OFF;
            mode_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!CYC_I) begin
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else if (wr_beat) begin
          err_d  = err_q + CNT_W'(popcnt4(diff));
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_W'(FRAME_SYMS - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        funce_d     = frame_err;
        correct_d   = frame_ok;
        done_d      = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
        // Re-arm only after the master releases CYC_I.
        need_low_d  = CYC_I;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_OFF;
      need_low_q  <= 1'b0;
      ack_q       <= 1'b0;
      beat_q      <= '0;
      err_q       <= '0;
      funce_q     <= '0;
      correct_q   <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      mode_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      need_low_q  <= need_low_d;
      ack_q       <= ack_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      funce_q     <= funce_d;
      correct_q   <= correct_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      mode_err_q  <= mode_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign ACK_O       = ack_q;
  assign funcE       = funce_q;
  assign correctbits = correct_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign mode_err    = mode_err_q;
  assign frame_cnt   = frame_cnt_q;

`ifdef ERR_ACCUM_EN
  logic [23:0] err_accum_q, err_accum_d;
  logic [24:0] acc_sum;

  always_comb begin
    acc_sum     = {1'b0, err_accum_q} + 25'(frame_err);
    err_accum_d = err_accum_q;
    if (state_q == ST_DONE) begin
      err_accum_d = acc_sum[24] ? 24'hFFFFFF : acc_sum[23:0];
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      err_accum_q <= '0;
    end else begin
      err_accum_q <= err_accum_d;
    end
  end

  assign err_accum = err_accum_q;
`endif

endmodule

// File: tb/tb_wb_rx_ber_sink.sv
// Self-checking bench for wb_rx_ber_sink: table of frames scored through a
// queue of expected results, plus abort, async-reset and mode corner sequences.
module tb_wb_rx_ber_sink;

  logic       clk = 1'b0;
  logic       RST_I = 1'b0;
  logic [3:0] DAT_I = 4'd0;
  logic       CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0;
  logic       QAM = 1'b0, QPSK = 1'b0;
  logic       ACK_O, frame_done, frame_abort, mode_err;
  logic [9:0] funcE, correctbits;
  logic [15:0] frame_cnt;
`ifdef ERR_ACCUM_EN
  logic [23:0] err_accum;
`endif

  always #5 clk = ~clk;

  wb_rx_ber_sink dut (
    .CLK_I(clk), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
    .ACK_O(ACK_O), .QAM(QAM), .QPSK(QPSK), .funcE(funcE), .correctbits(correctbits),
    .frame_done(frame_done), .frame_abort(frame_abort), .mode_err(mode_err),
    .frame_cnt(frame_cnt)
`ifdef ERR_ACCUM_EN
    , .err_accum(err_accum)
`endif
  );

  typedef struct {
    logic       qam;
    logic       qpsk;
    int         err_beat;
    logic [3:0] err_mask;
    int         rd_beat;
    logic [9:0] exp_funce;
    logic [9:0] exp_correct;
  } vec_t;

  typedef struct {
    logic [9:0]  funce;
    logic [9:0]  correct;
    logic [15:0] fcnt;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int done_pulses = 0, abort_pulses = 0, ack_total = 0, ack_b2b = 0;
  logic ack_prev = 1'b0;
  logic [8:0] m_lfsr;
  logic [15:0] exp_frames = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ACK_O) ack_total++;
    if (ACK_O && ack_prev) ack_b2b++;
    ack_prev = ACK_O;
    if (frame_abort) abort_pulses++;
    if (frame_done) begin
      done_pulses++;
      check("done_has_expect", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("funcE", 32'(funcE), 32'(e.funce));
        check("correctbits", 32'(correctbits), 32'(e.correct));
        check("frame_cnt", 32'(frame_cnt), 32'(e.fcnt));
        $display("frame %0d: funcE=%0d correctbits=%0d", frame_cnt, funcE, correctbits);
      end
    end
  end

  task automatic model_bits(input int n, output logic [3:0] b);
    b = 4'd0;
    for (int k = 0; k < n; k++) begin
      b[3-k] = m_lfsr[8];
      m_lfsr = {m_lfsr[7:0], m_lfsr[8] ^ m_lfsr[4]};
    end
  endtask

  // Drives one frame with STB_I held high; drops CYC_I after nbeats write ACKs.
  task automatic run_frame(input logic qam, input logic qpsk, input int nbeats,
                           input int err_beat, input logic [3:0] err_mask,
                           input int rd_beat, input int rst_at, output int acks);
    logic [3:0] b;
    logic [3:0] m;
    int bits, idx, slots, guard;
    bits = qam ? 4 : (qpsk ? 2 : 0);
    m_lfsr = 9'h1FF;
    acks = 0;
    idx = 0;
    slots = nbeats + ((rd_beat >= 0) ? 1 : 0);
    @(negedge clk);
    QAM = qam; QPSK = qpsk; CYC_I = 1'b1; STB_I = 1'b1;
    for (int s = 0; s < slots; s++) begin
      if (s == rd_beat) begin
        WE_I = 1'b0;
        DAT_I = 4'($urandom_range(15, 0));
      end else begin
        WE_I = 1'b1;
        model_bits(bits, b);
        m = (idx == err_beat) ? err_mask : 4'd0;
        if (qam) DAT_I = b ^ m;
        else if (qpsk) DAT_I = {2'($urandom_range(3, 0)), b[3:2] ^ m[1:0]};
        else DAT_I = 4'($urandom_range(15, 0));
        idx++;
      end
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!ACK_O && guard < 20);
      if (!ACK_O) begin
        check("ack_seen", 32'(ACK_O), 1);
        break;
      end
      acks++;
      if (acks == rst_at) begin
        #2 RST_I = 1'b0;
        #1;
        check("rst_ack", 32'(ACK_O), 0);
        check("rst_funcE", 32'(funcE), 0);
        check("rst_correct", 32'(correctbits), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_mode_err", 32'(mode_err), 0);
        break;
      end
    end
    STB_I = 1'b0; WE_I = 1'b0; CYC_I = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("sb_drained", 32'(sb_q.size()), 0);
  endtask

  task automatic push_exp(input logic [9:0] f, input logic [9:0] c);
    exp_t e;
    exp_frames = exp_frames + 16'd1;
    e.funce = f; e.correct = c; e.fcnt = exp_frames;
    sb_q.push_back(e);
  endtask

  vec_t vecs[7];

  initial begin
    int acks, a0, d0;
    vecs[0] = '{1'b1, 1'b0, -1, 4'b0000, -1, 10'd0, 10'd384};
    vecs[1] = '{1'b0, 1'b1, 10, 4'b0011, -1, 10'd2, 10'd190};
    vecs[2] = '{1'b1, 1'b0,  0, 4'b1000,  5, 10'd1, 10'd383};
    vecs[3] = '{1'b1, 1'b1, 95, 4'b1111, -1, 10'd4, 10'd380};
    vecs[4] = '{1'b0, 1'b0, 20, 4'b1111, -1, 10'd0, 10'd0};
    vecs[5] = '{1'b1, 1'b0, 50, 4'b0101, -1, 10'd2, 10'd382};
    vecs[6] = '{1'b0, 1'b1, 95, 4'b0001, -1, 10'd1, 10'd191};

    repeat (3) @(negedge clk);
    check("reset_ack", 32'(ACK_O), 0);
    check("reset_funcE", 32'(funcE), 0);
    check("reset_correct", 32'(correctbits), 0);
    check("reset_frame_cnt", 32'(frame_cnt), 0);
    check("reset_mode_err", 32'(mode_err), 0);
    check("reset_done", 32'(frame_done), 0);
    RST_I = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      a0 = ack_total;
      push_exp(vecs[i].exp_funce, vecs[i].exp_correct);
      run_frame(vecs[i].qam, vecs[i].qpsk, 96, vecs[i].err_beat, vecs[i].err_mask,
                vecs[i].rd_beat, -1, acks);
      drain();
      repeat (2) @(negedge clk);
      check("ack_count", 32'(ack_total - a0), 32'(96 + ((vecs[i].rd_beat >= 0) ? 1 : 0)));
      $display("vector %0d: qam=%0b qpsk=%0b acks=%0d", i, vecs[i].qam, vecs[i].qpsk, acks);
    end
    check("done_pulses", 32'(done_pulses), 7);
    check("mode_err_sticky", 32'(mode_err), 1);
    check("ack_back_to_back", 32'(ack_b2b), 0);

    // Early CYC_I drop: results hold, no frame_done.
    a0 = abort_pulses; d0 = done_pulses;
    run_frame(1'b1, 1'b0, 40, -1, 4'd0, -1, -1, acks);
    repeat (4) @(negedge clk);
    check("abort_pulse", 32'(abort_pulses - a0), 1);
    check("abort_no_done", 32'(done_pulses - d0), 0);
    check("abort_hold_funcE", 32'(funcE), 1);
    check("abort_hold_correct", 32'(correctbits), 191);
    check("abort_hold_cnt", 32'(frame_cnt), 32'(exp_frames));
    $display("abort after %0d beats", acks);
    push_exp(10'd0, 10'd384);
    run_frame(1'b1, 1'b0, 96, -1, 4'd0, -1, -1, acks);
    drain();

    // Asynchronous reset mid-frame at beat 50.
    run_frame(1'b1, 1'b0, 96, -1, 4'd0, -1, 50, acks);
    $display("reset asserted at beat %0d", acks);
    repeat (2) @(negedge clk);
    RST_I = 1'b1;
    exp_frames = 16'd0;
    repeat (2) @(negedge clk);
    push_exp(10'd0, 10'd384);
    run_frame(1'b1, 1'b0, 96, -1, 4'd0, -1, -1, acks);
    drain();
    check("ack_back_to_back_end", 32'(ack_b2b), 0);

`ifdef ERR_ACCUM_EN
    check("accum_clean", 32'(err_accum), 0);
    for (int i = 0; i < 2; i++) begin
      push_exp(10'd3, 10'd381);
      run_frame(1'b1, 1'b0, 96, 7 + i, 4'b0111, -1, -1, acks);
      drain();
    end
    repeat (2) @(negedge clk);
    check("accum_six", 32'(err_accum), 6);
    force dut.err_accum_q = 24'hFFFFFD;
    @(negedge clk);
    release dut.err_accum_q;
    push_exp(10'd3, 10'd381);
    run_frame(1'b1, 1'b0, 96, 3, 4'b1110, -1, -1, acks);
    drain();
    repeat (2) @(negedge clk);
    check("accum_sat", 32'(err_accum), 32'h00FFFFFF);
    push_exp(10'd1, 10'd383);
    run_frame(1'b1, 1'b0, 96, 3, 4'b0001, -1, -1, acks);
    drain();
    repeat (2) @(negedge clk);
    check("accum_hold", 32'(err_accum), 32'h00FFFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
